vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, successor to the fixed 640x480@60Hz sync block. It produces pixel/line counters, a display-enable flag, programmable-polarity sync outputs, line/frame strobes, a vblank flag and a frame counter. All outputs are registered and mutually coherent on every clock. It sits between the clock divider and the pixel/colour generator and supports any mode via parameters, plus a pixel clock-enable for running from a faster system clock.

---
 rtl/vga_timing_gen.sv | 132 +++++++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, sync, blanking,
// line/frame strobes and a frame counter, all registered from next-state counters.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CNT_W    = 10,
   parameter int FRAME_W  = 8
) (
   input  logic               clk_VGA,
   input  logic               rst_n,
   input  logic               ce,
   input  logic               en,
   output logic [CNT_W-1:0]   x_count,
   output logic [CNT_W-1:0]   y_count,
   output logic               displayArea,
   output logic               VGA_hsync,
   output logic               VGA_vsync,
   output logic               line_start,
   output logic               frame_start,
   output logic               vblank,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   // Window bounds are one bit wider so a sync ending exactly at the total still fits.
   localparam logic [CNT_W:0] H_ACT_END = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0] HS_START  = (CNT_W+1)'(H_ACTIVE + H_FP);
   localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W:0] V_ACT_END = (CNT_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0] VS_START  = (CNT_W+1)'(V_ACTIVE + V_FP);
   localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0]   r_x;
   logic [CNT_W-1:0]   r_y;
   logic               r_de;
   logic               r_hs;
   logic               r_vs;
   logic               r_ls;
   logic               r_fs;
   logic               r_vb;
   logic [FRAME_W-1:0] r_fc;

   logic               w_xWrap;
   logic               w_yWrap;
   logic [CNT_W-1:0]   w_nextX;
   logic [CNT_W-1:0]   w_nextY;
   logic [CNT_W:0]     w_nextXw;
   logic [CNT_W:0]     w_nextYw;
   logic               w_de;
   logic               w_hsActive;
   logic               w_vsActive;
   logic               w_vb;

   always_comb begin
      w_xWrap    = (r_x == H_LAST);
      w_yWrap    = (r_y == V_LAST);
      w_nextX    = w_xWrap ? '0 : r_x + CNT_W'(1);
      w_nextY    = r_y;
      if (w_xWrap) begin
         w_nextY = w_yWrap ? '0 : r_y + CNT_W'(1);
      end
      w_nextXw   = {1'b0, w_nextX};
      w_nextYw   = {1'b0, w_nextY};
      w_de       = (w_nextXw < H_ACT_END) && (w_nextYw < V_ACT_END);
      w_hsActive = (w_nextXw >= HS_START) && (w_nextXw < HS_END);
      w_vsActive = (w_nextYw >= VS_START) && (w_nextYw < VS_END);
      w_vb       = (w_nextYw >= V_ACT_END);
   end

   // en=0 parks on the last pixel so the next advance always lands on a frame boundary.
   always_ff @(posedge clk_VGA or negedge rst_n) begin
      if (!rst_n) begin
         r_x  <= H_LAST;
         r_y  <= V_LAST;
         r_de <= 1'b0;
         r_hs <= ~HS_POL;
         r_vs <= ~VS_POL;
         r_ls <= 1'b0;
         r_fs <= 1'b0;
         r_vb <= 1'b1;
         r_fc <= '0;
      end else if (!en) begin
         r_x  <= H_LAST;
         r_y  <= V_LAST;
         r_de <= 1'b0;
         r_hs <= ~HS_POL;
         r_vs <= ~VS_POL;
         r_ls <= 1'b0;
         r_fs <= 1'b0;
         r_vb <= 1'b1;
      end else if (ce) begin
         r_x  <= w_nextX;
         r_y  <= w_nextY;
         r_de <= w_de;
         r_hs <= w_hsActive ? HS_POL : ~HS_POL;
         r_vs <= w_vsActive ? VS_POL : ~VS_POL;
         r_ls <= w_xWrap;
         r_fs <= w_xWrap && w_yWrap;
         r_vb <= w_vb;
         if (w_xWrap && w_yWrap) begin
            r_fc <= r_fc + FRAME_W'(1);
         end
      end else begin
         r_ls <= 1'b0;
         r_fs <= 1'b0;
      end
   end

   assign x_count     = r_x;
   assign y_count     = r_y;
   assign displayArea = r_de;
   assign VGA_hsync   = r_hs;
   assign VGA_vsync   = r_vs;
   assign line_start  = r_ls;
   assign frame_start = r_fs;
   assign vblank      = r_vb;
   assign frame_count = r_fc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: a default 640x480 instance and a tiny-mode
// instance, both compared every clock against a raster-position reference model.
module tb_vga_timing_gen;

   typedef struct {
      int pos;
      bit parked;
      bit adv;
      int fc;
   } modelState;

   typedef struct {
      int x;
      int y;
      int de;
      int hs;
      int vs;
      int ls;
      int fs;
      int vb;
      int fc;
   } expOut;

   logic clk;
   logic rst_n;
   logic ce;
   logic en;

   logic [9:0] aX, aY, bX, bY;
   logic       aDe, aHs, aVs, aLs, aFs, aVb;
   logic       bDe, bHs, bVs, bLs, bFs, bVb;
   logic [7:0] aFc, bFc;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int linePeriodExp = 0;
   int lastLine = -1;
   int framePeriodExp = 0;
   int lastFrame = -1;

   modelState mA, mB;

   vga_timing_gen dutA (
      .clk_VGA(clk), .rst_n(rst_n), .ce(ce), .en(en),
      .x_count(aX), .y_count(aY), .displayArea(aDe),
      .VGA_hsync(aHs), .VGA_vsync(aVs), .line_start(aLs),
      .frame_start(aFs), .vblank(aVb), .frame_count(aFc)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0)
   ) dutB (
      .clk_VGA(clk), .rst_n(rst_n), .ce(ce), .en(en),
      .x_count(bX), .y_count(bY), .displayArea(bDe),
      .VGA_hsync(bHs), .VGA_vsync(bVs), .line_start(bLs),
      .frame_start(bFs), .vblank(bVb), .frame_count(bFc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raster is modelled as a linear pixel index within the frame.
   function automatic modelState modelReset(int total);
      modelState m;
      m.pos    = total - 1;
      m.parked = 1'b1;
      m.adv    = 1'b0;
      m.fc     = 0;
      return m;
   endfunction

   function automatic modelState modelStep(modelState mi, bit enIn, bit ceIn, int total);
      modelState m = mi;
      m.adv = 1'b0;
      if (!enIn) begin
         m.pos    = total - 1;
         m.parked = 1'b1;
      end else if (ceIn) begin
         m.pos    = (m.pos + 1) % total;
         m.parked = 1'b0;
         m.adv    = 1'b1;
         if (m.pos == 0) m.fc = (m.fc + 1) % 256;
      end
      return m;
   endfunction

   function automatic expOut predict(modelState m, int ha, int hf, int hsw, int hb,
                                     int va, int vf, int vsw, bit hp, bit vp);
      expOut e;
      int ht = ha + hf + hsw + hb;
      e.x  = m.pos % ht;
      e.y  = m.pos / ht;
      e.ls = (m.adv && e.x == 0) ? 1 : 0;
      e.fs = (m.adv && m.pos == 0) ? 1 : 0;
      e.fc = m.fc;
      if (m.parked) begin
         e.de = 0;
         e.vb = 1;
         e.hs = hp ? 0 : 1;
         e.vs = vp ? 0 : 1;
      end else begin
         e.de = (e.x < ha && e.y < va) ? 1 : 0;
         e.vb = (e.y >= va) ? 1 : 0;
         e.hs = ((e.x >= ha + hf && e.x < ha + hf + hsw) == hp) ? 1 : 0;
         e.vs = ((e.y >= va + vf && e.y < va + vf + vsw) == vp) ? 1 : 0;
      end
      return e;
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectors++;
      if (observed != expected) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
      end
   endtask

   task automatic checkAll();
      expOut pa, pb;
      pa = predict(mA, 640, 16, 96, 48, 480, 10, 2, 1'b0, 1'b0);
      pb = predict(mB, 8, 1, 2, 1, 4, 1, 1, 1'b1, 1'b0);
      checkOutput("A.x", 32'(aX), pa.x);
      checkOutput("A.y", 32'(aY), pa.y);
      checkOutput("A.de", 32'(aDe), pa.de);
      checkOutput("A.hs", 32'(aHs), pa.hs);
      checkOutput("A.vs", 32'(aVs), pa.vs);
      checkOutput("A.ls", 32'(aLs), pa.ls);
      checkOutput("A.fs", 32'(aFs), pa.fs);
      checkOutput("A.vb", 32'(aVb), pa.vb);
      checkOutput("A.fc", 32'(aFc), pa.fc);
      checkOutput("B.x", 32'(bX), pb.x);
      checkOutput("B.y", 32'(bY), pb.y);
      checkOutput("B.de", 32'(bDe), pb.de);
      checkOutput("B.hs", 32'(bHs), pb.hs);
      checkOutput("B.vs", 32'(bVs), pb.vs);
      checkOutput("B.ls", 32'(bLs), pb.ls);
      checkOutput("B.fs", 32'(bFs), pb.fs);
      checkOutput("B.vb", 32'(bVb), pb.vb);
      checkOutput("B.fc", 32'(bFc), pb.fc);
      if (linePeriodExp != 0 && aLs) begin
         if (lastLine >= 0) checkOutput("A.linePeriod", cyc - lastLine, linePeriodExp);
         lastLine = cyc;
      end
      if (framePeriodExp != 0 && bFs) begin
         if (lastFrame >= 0) checkOutput("B.framePeriod", cyc - lastFrame, framePeriodExp);
         lastFrame = cyc;
      end
   endtask

   // Inputs change just after the falling edge; outputs are checked on the next falling edge.
   task automatic applyStimulus(input bit enIn, input bit ceIn);
      en = enIn;
      ce = ceIn;
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         mA = modelStep(mA, enIn, ceIn, 800 * 525);
         mB = modelStep(mB, enIn, ceIn, 12 * 7);
      end
      @(negedge clk);
      checkAll();
   endtask

   initial begin
      int savedFc;
      int budget;
      rst_n = 1'b0;
      en    = 1'b0;
      ce    = 1'b0;
      mA    = modelReset(800 * 525);
      mB    = modelReset(12 * 7);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1);
      checkOutput("rst.x", 32'(aX), 799);
      checkOutput("rst.y", 32'(aY), 524);
      checkOutput("rst.bx", 32'(bX), 11);
      rst_n = 1'b1;

      linePeriodExp = 800;
      lastLine = -1;
      applyStimulus(1'b1, 1'b1);
      checkOutput("first.x", 32'(aX), 0);
      checkOutput("first.fs", 32'(aFs), 1);
      checkOutput("first.fc", 32'(aFc), 1);
      for (int i = 0; i < 2500; i++) applyStimulus(1'b1, 1'b1);

      linePeriodExp = 3200;
      lastLine = -1;
      for (int i = 0; i < 7000; i++) applyStimulus(1'b1, (cyc % 4) == 3);

      linePeriodExp = 0;
      budget = 0;
      while ((mA.pos % 800) != 300 && budget < 2000) begin
         applyStimulus(1'b1, 1'b1);
         budget++;
      end
      checkOutput("reach300.timeout", (budget < 2000) ? 1 : 0, 1);
      savedFc = mA.fc;
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      checkOutput("park.x", 32'(aX), 799);
      checkOutput("park.y", 32'(aY), 524);
      checkOutput("park.hs", 32'(aHs), 1);
      checkOutput("park.vs", 32'(aVs), 1);
      checkOutput("park.de", 32'(aDe), 0);
      checkOutput("park.fc", 32'(aFc), savedFc);
      applyStimulus(1'b1, 1'b1);
      checkOutput("restart.x", 32'(aX), 0);
      checkOutput("restart.y", 32'(aY), 0);
      checkOutput("restart.fs", 32'(aFs), 1);

      for (int i = 0; i < 6000; i++)
         applyStimulus($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)));

      framePeriodExp = 84;
      lastFrame = -1;
      for (int i = 0; i < 22000; i++) applyStimulus(1'b1, 1'b1);
      framePeriodExp = 0;

      for (int i = 0; i < 37; i++) applyStimulus(1'b1, 1'b1);
      #2 rst_n = 1'b0;
      mA = modelReset(800 * 525);
      mB = modelReset(12 * 7);
      #1;
      checkOutput("async.x", 32'(aX), 799);
      checkOutput("async.y", 32'(aY), 524);
      checkOutput("async.de", 32'(aDe), 0);
      checkOutput("async.vb", 32'(aVb), 1);
      checkOutput("async.fc", 32'(aFc), 0);
      checkOutput("async.bhs", 32'(bHs), 0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1);
      rst_n = 1'b1;
      for (int i = 0; i < 300; i++)
         applyStimulus($urandom_range(0, 31) != 0, 1'($urandom_range(0, 2) != 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
